// File: rtl/dmas_chnl_frontend.sv
// DMAS/DAS channel front-end: sign/magnitude split of signed RF samples with valid/ready
// flow control, frame markers and per-pixel zero-flush. Optional sat_cnt via DMAS_SAT_CNT_EN.
`timescale 1ns/1ps
module dmas_chnl_frontend #(
  parameter int DW        = 16,
  parameter int CHANNELS  = 128,
  parameter int CH_BITS   = 8,
  parameter int PIXELS    = 1,
  parameter int PIX_BITS  = 1,
  parameter int FLUSH_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DW-1:0]       out_mag,
  output logic [1:0]          out_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eof,
  output logic                out_flush,
  output logic [PIX_BITS-1:0] out_pixel,
  output logic                busy,
  output logic                done
`ifdef DMAS_SAT_CNT_EN
  ,
  output logic [CH_BITS+PIX_BITS-1:0] sat_cnt
`endif
);

  localparam int FL_BITS = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CH_BITS-1:0]  CH_LAST  = CH_BITS'(CHANNELS - 1);
  localparam logic [PIX_BITS-1:0] PIX_LAST = PIX_BITS'(PIXELS - 1);
  localparam logic [FL_BITS-1:0]  FL_LAST  = FL_BITS'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
  localparam logic [DW-1:0]       MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]       MOST_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [1:0]          SIGN_POS = 2'b01;
  localparam logic [1:0]          SIGN_NEG = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, LAST} state_t;

  state_t                state_reg, state_next;
  logic [CH_BITS-1:0]    ch_cnt_reg, ch_cnt_next;
  logic [PIX_BITS-1:0]   pix_cnt_reg, pix_cnt_next;
  logic [FL_BITS-1:0]    fl_cnt_reg, fl_cnt_next;
  logic                  mode_reg, mode_next;
  logic [DW-1:0]         mag_reg, mag_next;
  logic [1:0]            sign_reg, sign_next;
  logic                  valid_reg, valid_next;
  logic                  sof_reg, sof_next;
  logic                  eof_reg, eof_next;
  logic                  flush_reg, flush_next;
  logic [PIX_BITS-1:0]   pixel_reg, pixel_next;
  logic                  done_reg, done_next;

  logic                  adv;
  logic                  xfer;
  logic [DW-1:0]         neg_data;
  logic [DW-1:0]         smp_mag;
  logic [1:0]            smp_sign;
  logic                  sat_hit;

  assign adv      = out_ready || !valid_reg;
  assign in_ready = adv && (state_reg == RUN);
  assign xfer     = in_valid && in_ready;
  assign neg_data = ~in_data + 1'b1;
  assign sat_hit  = !mode_reg && (in_data == MOST_NEG);

  // The most-negative code has no positive twin, so it clamps to the largest magnitude.
  always_comb begin
    smp_mag  = in_data;
    smp_sign = SIGN_POS;
    if (!mode_reg && in_data[DW-1]) begin
      smp_sign = SIGN_NEG;
      smp_mag  = (in_data == MOST_NEG) ? MOST_POS : neg_data;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ch_cnt_next  = ch_cnt_reg;
    pix_cnt_next = pix_cnt_reg;
    fl_cnt_next  = fl_cnt_reg;
    mode_next    = mode_reg;
    mag_next     = mag_reg;
    sign_next    = sign_reg;
    valid_next   = valid_reg;
    sof_next     = sof_reg;
    eof_next     = eof_reg;
    flush_next   = flush_reg;
    pixel_next   = pixel_reg;
    done_next    = 1'b0;

    // Once the current word is gone, the register empties unless something reloads it below.
    if (adv) begin
      valid_next = 1'b0;
      mag_next   = '0;
      sign_next  = SIGN_POS;
      sof_next   = 1'b0;
      eof_next   = 1'b0;
      flush_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          mode_next    = mode;
          ch_cnt_next  = '0;
          pix_cnt_next = '0;
          fl_cnt_next  = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          valid_next  = 1'b1;
          mag_next    = smp_mag;
          sign_next   = smp_sign;
          sof_next    = (ch_cnt_reg == '0);
          eof_next    = (ch_cnt_reg == CH_LAST);
          flush_next  = 1'b0;
          pixel_next  = pix_cnt_reg;
          ch_cnt_next = ch_cnt_reg + 1'b1;
          if (ch_cnt_reg == CH_LAST) begin
            ch_cnt_next = '0;
            fl_cnt_next = '0;
            if (FLUSH_LEN > 0) begin
              state_next = FLUSH;
            end else if (pix_cnt_reg == PIX_LAST) begin
              state_next = LAST;
            end else begin
              pix_cnt_next = pix_cnt_reg + 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          valid_next  = 1'b1;
          flush_next  = 1'b1;
          pixel_next  = pix_cnt_reg;
          fl_cnt_next = fl_cnt_reg + 1'b1;
          if (fl_cnt_reg == FL_LAST) begin
            fl_cnt_next = '0;
            if (pix_cnt_reg == PIX_LAST) begin
              state_next = LAST;
            end else begin
              state_next   = RUN;
              pix_cnt_next = pix_cnt_reg + 1'b1;
            end
          end
        end
      end
      LAST: begin
        if (adv) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt_reg  <= '0;
      pix_cnt_reg <= '0;
      fl_cnt_reg  <= '0;
      mode_reg    <= 1'b0;
      mag_reg     <= '0;
      sign_reg    <= SIGN_POS;
      valid_reg   <= 1'b0;
      sof_reg     <= 1'b0;
      eof_reg     <= 1'b0;
      flush_reg   <= 1'b0;
      pixel_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      ch_cnt_reg  <= ch_cnt_next;
      pix_cnt_reg <= pix_cnt_next;
      fl_cnt_reg  <= fl_cnt_next;
      mode_reg    <= mode_next;
      mag_reg     <= mag_next;
      sign_reg    <= sign_next;
      valid_reg   <= valid_next;
      sof_reg     <= sof_next;
      eof_reg     <= eof_next;
      flush_reg   <= flush_next;
      pixel_reg   <= pixel_next;
      done_reg    <= done_next;
    end
  end

`ifdef DMAS_SAT_CNT_EN
  logic [CH_BITS+PIX_BITS-1:0] sat_cnt_reg, sat_cnt_next;

  always_comb begin
    sat_cnt_next = sat_cnt_reg;
    if (state_reg == IDLE && start) begin
      sat_cnt_next = '0;
    end else if (xfer && sat_hit && (sat_cnt_reg != '1)) begin
      sat_cnt_next = sat_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt_reg <= '0;
    end else begin
      sat_cnt_reg <= sat_cnt_next;
    end
  end

  assign sat_cnt = sat_cnt_reg;
`else
  logic unused_sat;
  assign unused_sat = sat_hit;
`endif

  assign out_mag   = mag_reg;
  assign out_sign  = sign_reg;
  assign out_valid = valid_reg;
  assign out_sof   = sof_reg;
  assign out_eof   = eof_reg;
  assign out_flush = flush_reg;
  assign out_pixel = pixel_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_dmas_chnl_frontend.sv
// Bench for dmas_chnl_frontend: default-size instance with random stimulus and
// back-pressure, plus a small multi-pixel instance (PIXELS=3, CHANNELS=4, FLUSH_LEN=2).
`timescale 1ns/1ps
module tb_dmas_chnl_frontend;

  typedef struct packed {
    logic [15:0] mag;
    logic [1:0]  sign;
    logic        sof;
    logic        eof;
    logic        flush;
    logic [1:0]  pix;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_sof, out_eof, out_flush, busy, done;
  logic [15:0] out_mag;
  logic [1:0]  out_sign;
  logic [0:0]  out_pixel;

  logic        s_start = 1'b0, s_mode = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [15:0] s_in_data = '0;
  logic        s_in_ready, s_out_valid, s_out_sof, s_out_eof, s_out_flush, s_busy, s_done;
  logic [15:0] s_out_mag;
  logic [1:0]  s_out_sign;
  logic [1:0]  s_out_pixel;
`ifdef DMAS_SAT_CNT_EN
  logic [8:0]  sat_cnt;
  logic [4:0]  s_sat_cnt;
`endif

  int    errors = 0, checks = 0;
  int    samp[128];
  int    ss[12];
  word_t exp_q[$];
  word_t s_obs[$];
  bit    mon_en = 1'b0;
  int    stall_pct = 0;
  int    widx = 0, done_cnt = 0, ncyc = 0, done_cyc = -1, last_xfer_cyc = -2, s_done_cnt = 0;

  always #5 clk = ~clk;

  dmas_chnl_frontend u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_mag(out_mag), .out_sign(out_sign), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .out_flush(out_flush), .out_pixel(out_pixel),
    .busy(busy), .done(done)
`ifdef DMAS_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  dmas_chnl_frontend #(.CHANNELS(4), .CH_BITS(3), .PIXELS(3), .PIX_BITS(2), .FLUSH_LEN(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_mag(s_out_mag), .out_sign(s_out_sign), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sof(s_out_sof), .out_eof(s_out_eof), .out_flush(s_out_flush), .out_pixel(s_out_pixel),
    .busy(s_busy), .done(s_done)
`ifdef DMAS_SAT_CNT_EN
    , .sat_cnt(s_sat_cnt)
`endif
  );

  // Reference: magnitude is |x| clamped to 32767; sign is -1 only for negative DMAS samples.
  function automatic word_t ref_word(input int x, input bit das, input int idx, input int nch, input int pix);
    word_t w;
    int    m;
    w.sof   = (idx == 0);
    w.eof   = (idx == nch - 1);
    w.flush = 1'b0;
    w.pix   = 2'(pix);
    w.sign  = 2'b01;
    w.mag   = 16'(x);
    if (!das && x < 0) begin
      m = -x;
      if (m > 32767) m = 32767;
      w.sign = 2'b11;
      w.mag  = 16'(m);
    end
    return w;
  endfunction

  function automatic word_t flush_word(input int pix);
    word_t w;
    w = '0;
    w.sign  = 2'b01;
    w.flush = 1'b1;
    w.pix   = 2'(pix);
    return w;
  endfunction

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      out_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
    end
  endtask

  task automatic monitor();
    word_t cur, held;
    bit    hold_prev;
    hold_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (s_out_valid && s_out_ready)
        s_obs.push_back('{s_out_mag, s_out_sign, s_out_sof, s_out_eof, s_out_flush, s_out_pixel});
      if (s_done) s_done_cnt++;
      if (!mon_en) begin
        hold_prev = 1'b0;
        continue;
      end
      cur = '{out_mag, out_sign, out_sof, out_eof, out_flush, 2'(out_pixel)};
      if (hold_prev) begin
        checks++;
        if (!out_valid || cur !== held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b word=%h, required valid=1 word=%h", out_valid, cur, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall: got %0b, required 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (widx >= exp_q.size()) begin
          errors++;
          $display("FAIL extra_word: got word %0d=%h, required only %0d words", widx, cur, exp_q.size());
        end else if (cur !== exp_q[widx]) begin
          errors++;
          $display("FAIL word_%0d: got %h, required %h", widx, cur, exp_q[widx]);
        end
        widx++;
        last_xfer_cyc = ncyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
      end
      hold_prev = out_valid && !out_ready;
      held = cur;
    end
  endtask

  // Feed n samples to the default instance; returns how many were accepted.
  task automatic feed(input int n, output int idx);
    int t;
    idx = 0;
    t = 0;
    while (idx < n && t < 4000) begin
      in_data  = 16'(samp[idx]);
      in_valid = 1'b1;
      if (stall_pct != 0) in_valid = (int'($urandom_range(99)) >= 20);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_big(input bit das, input int spct, input string name);
    int idx, t;
    exp_q.delete();
    for (int c = 0; c < 128; c++) exp_q.push_back(ref_word(samp[c], das, c, 128, 0));
    for (int f = 0; f < 5; f++) exp_q.push_back(flush_word(0));
    widx = 0; done_cnt = 0; done_cyc = -1; last_xfer_cyc = -2;
    stall_pct = spct;
    mon_en = 1'b1;
    @(posedge clk); #1;
    mode = das; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~das;
    feed(128, idx);
    checks++;
    if (idx != 128) begin
      errors++;
      $display("FAIL %s_accept: got %0d samples accepted, required 128", name, idx);
    end
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    stall_pct = 0;
    checks++;
    if (widx != 133) begin errors++; $display("FAIL %s_words: got %0d, required 133", name, widx); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt); end
    checks++;
    if (done_cyc != last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing: got cycle %0d, required %0d", name, done_cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %0b, required 0", name, busy); end
    mon_en = 1'b0;
    $display("run %s: %0d words, done_cnt=%0d", name, widx, done_cnt);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_mag !== 16'd0 || out_sign !== 2'b01 || out_sof !== 1'b0 ||
        out_eof !== 1'b0 || out_flush !== 1'b0 || out_pixel !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%0b mag=%h sign=%b sof=%0b eof=%0b fl=%0b pix=%0d busy=%0b done=%0b rdy=%0b, required v=0 mag=0000 sign=01 rest 0",
               name, out_valid, out_mag, out_sign, out_sof, out_eof, out_flush, out_pixel, busy, done, in_ready);
    end
`ifdef DMAS_SAT_CNT_EN
    checks++;
    if (sat_cnt !== 9'd0) begin errors++; $display("FAIL %s_sat: got %0d, required 0", name, sat_cnt); end
`endif
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset_state");
    checks++;
    if (s_out_valid !== 1'b0 || s_out_sign !== 2'b01 || s_busy !== 1'b0 || s_out_pixel !== 2'd0) begin
      errors++;
      $display("FAIL reset_small: got v=%0b sign=%b busy=%0b pix=%0d, required 0/01/0/0", s_out_valid, s_out_sign, s_busy, s_out_pixel);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    $display("reset: checked");
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 128; i++) samp[i] = (i % 2 == 0) ? 100 : -100;
    run_big(1'b0, 0, "alternating");
  endtask

  task automatic test_saturation();
    int pos;
    for (int i = 0; i < 128; i++) samp[i] = int'($urandom_range(65534)) - 32767;
    pos = int'($urandom_range(127));
    samp[pos] = -32768;
    run_big(1'b0, 0, "saturation");
`ifdef DMAS_SAT_CNT_EN
    checks++;
    if (sat_cnt !== 9'd1) begin errors++; $display("FAIL sat_cnt: got %0d, required 1", sat_cnt); end
`endif
  endtask

  task automatic test_das();
    for (int i = 0; i < 128; i++) samp[i] = int'($urandom_range(65535)) - 32768;
    samp[3] = -5;
    samp[9] = -32768;
    run_big(1'b1, 0, "das");
`ifdef DMAS_SAT_CNT_EN
    checks++;
    if (sat_cnt !== 9'd0) begin errors++; $display("FAIL das_sat_cnt: got %0d, required 0", sat_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 128; i++) samp[i] = int'($urandom_range(65535)) - 32768;
    run_big(1'b0, 30, "backpressure");
  endtask

  task automatic test_reset_midrun();
    int idx;
    for (int i = 0; i < 128; i++) samp[i] = int'($urandom_range(2000)) - 1000;
    stall_pct = 0;
    @(posedge clk); #1;
    mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(50, idx);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: got busy=%0b valid=%0b, required 1/1", busy, out_valid);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 128; i++) samp[i] = int'($urandom_range(65535)) - 32768;
    run_big(1'b0, 0, "after_reset");
  endtask

  task automatic test_multi_pixel();
    int    idx, t, p, pos;
    word_t e;
    s_obs.delete();
    s_done_cnt = 0;
    for (int i = 0; i < 12; i++) ss[i] = int'($urandom_range(65535)) - 32768;
    ss[5] = -32768;
    @(posedge clk); #1;
    s_mode = 1'b0; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    idx = 0;
    t = 0;
    while (idx < 12 && t < 400) begin
      s_in_data  = 16'(ss[idx]);
      s_in_valid = 1'b1;
      @(negedge clk);
      if (s_in_valid && s_in_ready) idx++;
      @(posedge clk);
      #1;
      t++;
    end
    s_in_valid = 1'b0;
    t = 0;
    while (s_done_cnt == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (s_obs.size() != 18) begin errors++; $display("FAIL multi_words: got %0d, required 18", s_obs.size()); end
    for (int i = 0; i < 18 && i < s_obs.size(); i++) begin
      p = i / 6;
      pos = i % 6;
      e = (pos < 4) ? ref_word(ss[p * 4 + pos], 1'b0, pos, 4, p) : flush_word(p);
      checks++;
      if (s_obs[i] !== e) begin
        errors++;
        $display("FAIL multi_word_%0d: got %h, required %h", i, s_obs[i], e);
      end
    end
    checks++;
    if (s_done_cnt != 1) begin errors++; $display("FAIL multi_done: got %0d, required 1", s_done_cnt); end
`ifdef DMAS_SAT_CNT_EN
    checks++;
    if (s_sat_cnt !== 5'd1) begin errors++; $display("FAIL multi_sat_cnt: got %0d, required 1", s_sat_cnt); end
`endif
    $display("run multi_pixel: %0d words, done_cnt=%0d", s_obs.size(), s_done_cnt);
  endtask

  initial begin
    fork
      monitor();
      ready_driver();
    join_none
    test_reset();
    test_alternating();
    test_saturation();
    test_das();
    test_backpressure();
    test_reset_midrun();
    test_multi_pixel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmas_chnl_frontend.md
Name: dmas_chnl_frontend

Overview:
- Parametrised successor to the single-pixel DMAS channel front-end. Accepts a stream of signed RF samples, CHANNELS samples per pixel, over PIXELS pixels.
- Emits registered sign/magnitude pairs for the sqrt stage of the factorised DMAS pixel core, or the raw signed sample in DAS mode.
- Adds valid/ready flow control, frame markers, per-pixel zero-flush for the sqrt/accumulator pipeline, and saturation of the most-negative input.
- Sits between the RF sample buffer and the pixel-level DMAS/DAS beamforming core.

Parameters:
- DW, 16, RF sample width in bits (two's complement).
- CHANNELS, 128, samples per pixel frame.
- CH_BITS, 8, channel counter width; must satisfy 2^CH_BITS > CHANNELS.
- PIXELS, 1, pixel frames per run.
- PIX_BITS, 1, pixel counter width; must satisfy 2^PIX_BITS >= PIXELS.
- FLUSH_LEN, 5, zero samples emitted after each frame (set to sqrt IP latency).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a run when IDLE.
- mode  in  1  0 = DMAS (sign/magnitude), 1 = DAS (raw pass-through); sampled at start.
- in_data  in  DW  signed RF sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts sample this cycle.
- out_mag  out  DW  magnitude (DMAS) or raw sample (DAS).
- out_sign  out  2  signed +1 (2'b01) or -1 (2'b11).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts word.
- out_sof  out  1  first channel of a pixel frame.
- out_eof  out  1  last channel of a pixel frame.
- out_flush  out  1  word is a flush zero.
- out_pixel  out  PIX_BITS  pixel index of current word.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse after last flush word of last pixel is accepted.

Behaviour:
- Reset (asynchronous, rst low): state IDLE; all counters 0; out_mag 0; out_sign 2'b01; out_valid, out_sof, out_eof, out_flush, busy, done all 0; out_pixel 0. Reset mid-run aborts immediately; no partial frame is resumed.
- Handshake:
  - A transfer occurs on valid && ready at posedge.
  - Output register advances when out_ready || !out_valid (the "adv" condition).
  - in_ready = adv && state==RUN.
  - out_valid holds and all out_* fields remain stable while out_ready is low.
- States:
  - IDLE: start=1 -> RUN, latch mode, ch_cnt=0, pix_cnt=0. start is ignored outside IDLE.
  - RUN: each accepted sample loads the output register with 1-cycle latency and increments ch_cnt. The accept with ch_cnt==CHANNELS-1 -> FLUSH (fl_cnt=0), ch_cnt=0.
  - FLUSH: on each adv, emit out_mag=0, out_sign=2'b01, out_flush=1, out_valid=1 and increment fl_cnt. The word with fl_cnt==FLUSH_LEN-1 goes to RUN with pix_cnt+1, or to LAST if pix_cnt==PIXELS-1. FLUSH_LEN=0 skips FLUSH entirely.
  - LAST: wait until the final word is accepted (out_valid=0 or out_ready=1). Then pulse done for one cycle -> IDLE.
- Arithmetic, DMAS:
  - in_data<0: out_sign=2'b11, out_mag=-in_data.
  - in_data>=0: out_sign=2'b01, out_mag=in_data.
  - in_data = -2^(DW-1): out_mag saturates to 2^(DW-1)-1, out_sign=2'b11.
- Arithmetic, DAS: out_mag=in_data unchanged, out_sign=2'b01.
- When no transfer occurs while adv is true, out_valid drops to 0 and out_mag is cleared to 0.
- Markers:
  - out_sof=1 on the word from ch_cnt==0.
  - out_eof=1 on the word from ch_cnt==CHANNELS-1.
  - With CHANNELS=1, both are set on the same word.
- out_pixel is the pix_cnt of the source sample or flush word.

Optional Feature:
- Macro: DMAS_SAT_CNT_EN.
- Defined:
  - Adds output sat_cnt (CH_BITS+PIX_BITS wide), counting saturated samples in the current run.
  - Clears on start and on reset; holds its value after done.
  - Stops at all-ones without wrapping.
- Undefined: port and counter absent; saturation behaviour unchanged.

Test Plan:
- Defaults, start, 128 samples alternating +100/-100, out_ready=1 ->
  - words 0..127: mag 100, sign 01/11 alternating;
  - sof on word 0, eof on word 127;
  - then 5 flush zeros;
  - done 1 cycle after the last flush word.
- Input -32768 (DW=16), DMAS -> out_mag=32767, out_sign=2'b11; with DMAS_SAT_CNT_EN, sat_cnt=1.
- mode=1, input -5 -> out_mag=16'hFFFB, out_sign=2'b01.
- out_ready low for 3 cycles mid-frame -> in_ready=0, output held stable, no sample lost or duplicated; totals 128+5 words.
- PIXELS=3, CHANNELS=4, FLUSH_LEN=2 -> 18 words; out_pixel 0,0,0,0,0,0,1,...,2; exactly one done.
- rst asserted at channel 50 -> outputs at reset values immediately. A new start then gives a fresh frame with sof on the first sample.
